// File: rtl/memory_bus_responder_if.sv
// memory_bus_responder_if: granted-master memory bus plus snoop response signals
interface memory_bus_responder_if #(
  parameter int ADDRESS_WIDTH = 8,
  parameter int DATA_WIDTH = 16
);
  logic [ADDRESS_WIDTH-1:0] address;
  logic [DATA_WIDTH-1:0] dataOut;
  logic [DATA_WIDTH-1:0] dataIn;
  logic readEnabled;
  logic writeEnabled;
  logic functionComplete;
  logic [1:0] commandIn;
  logic snoopyHitIn;
  logic [DATA_WIDTH-1:0] snoopyDataIn;
  logic snoopyFunctionCompleteIn;
  logic protocolError;
  modport master (
    output address, dataOut, readEnabled, writeEnabled, commandIn,
    output snoopyHitIn, snoopyDataIn, snoopyFunctionCompleteIn,
    input  dataIn, functionComplete, protocolError
  );
  modport slave (
    input  address, dataOut, readEnabled, writeEnabled, commandIn,
    input  snoopyHitIn, snoopyDataIn, snoopyFunctionCompleteIn,
    output dataIn, functionComplete, protocolError
  );
endinterface

// File: rtl/memory_bus_responder.sv
// memory_bus_responder: main memory with cache-to-cache intervention; MEMORY_INTERVENTION_UPDATE_EN also writes intervened data to memory
module memory_bus_responder #(
  parameter int ADDRESS_WIDTH = 8,
  parameter int DATA_WIDTH = 16,
  parameter int ACCESS_LATENCY = 2
) (
  input logic clock,
  input logic reset,
  memory_bus_responder_if.slave bus
);
  localparam logic [1:0] BUS_READ = 2'd1;
  localparam logic [3:0] LATENCY = 4'(ACCESS_LATENCY);
`ifdef MEMORY_INTERVENTION_UPDATE_EN
  localparam logic UPDATE = 1'b1;
`else
  localparam logic UPDATE = 1'b0;
`endif
  typedef enum logic [1:0] {IDLE, WAIT, INTERVENE, COMPLETE} state_t;
  state_t state, state_n;
  logic [3:0] count, count_n;
  logic is_write, is_write_n;
  logic [DATA_WIDTH-1:0] data, data_n, mem_wdata;
  logic done, done_n, error, error_n, mem_we;
  logic [DATA_WIDTH-1:0] mem [2**ADDRESS_WIDTH];
  always_comb begin
    state_n = state;
    count_n = count;
    is_write_n = is_write;
    data_n = data;
    done_n = done;
    error_n = error | (bus.readEnabled & bus.writeEnabled);
    mem_we = 1'b0;
    mem_wdata = bus.dataOut;
    case (state)
      IDLE:
        if (bus.readEnabled && !bus.writeEnabled && bus.commandIn == BUS_READ && bus.snoopyHitIn)
          state_n = INTERVENE;
        else if (bus.readEnabled || bus.writeEnabled) begin
          count_n = LATENCY;
          is_write_n = bus.writeEnabled;
          state_n = WAIT;
        end
      WAIT:
        if (count != 4'd0)
          count_n = count - 4'd1;
        else begin
          mem_we = is_write;
          data_n = is_write ? data : mem[bus.address];
          done_n = 1'b1;
          state_n = COMPLETE;
        end
      INTERVENE:
        if (bus.snoopyFunctionCompleteIn) begin
          data_n = bus.snoopyDataIn;
          mem_we = UPDATE;
          mem_wdata = bus.snoopyDataIn;
          done_n = 1'b1;
          state_n = COMPLETE;
        end else if (!bus.snoopyHitIn) begin
          count_n = LATENCY;
          is_write_n = 1'b0;
          state_n = WAIT;
        end
      COMPLETE:
        if (!bus.readEnabled && !bus.writeEnabled) begin
          done_n = 1'b0;
          state_n = IDLE;
        end
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clock or negedge reset)
    if (!reset) begin
      state <= IDLE;
      count <= '0;
      is_write <= 1'b0;
      data <= '0;
      done <= 1'b0;
      error <= 1'b0;
    end else begin
      state <= state_n;
      count <= count_n;
      is_write <= is_write_n;
      data <= data_n;
      done <= done_n;
      error <= error_n;
    end
  // no reset on the array: contents survive reset
  always_ff @(posedge clock)
    if (mem_we) mem[bus.address] <= mem_wdata;
  assign bus.dataIn = data;
  assign bus.functionComplete = done;
  assign bus.protocolError = error;
endmodule

// File: tb/tb_memory_bus_responder.sv
// tb_memory_bus_responder: directed checks of memory access, intervention, fallback, protocol error and reset abort
module tb_memory_bus_responder;
  localparam logic [1:0] NONE = 2'd0;
  localparam logic [1:0] BUS_READ = 2'd1;
  localparam logic [1:0] BUS_WRITEBACK = 2'd2;
  logic clock = 1'b0;
  logic reset = 1'b0;
  int checks = 0;
  int failures = 0;
  int n;
  logic [15:0] rd;
  memory_bus_responder_if #(.ADDRESS_WIDTH(8), .DATA_WIDTH(16)) bus ();
  memory_bus_responder_if #(.ADDRESS_WIDTH(8), .DATA_WIDTH(16)) bus0 ();
  memory_bus_responder #(.ADDRESS_WIDTH(8), .DATA_WIDTH(16), .ACCESS_LATENCY(2)) dut (
    .clock(clock), .reset(reset), .bus(bus));
  memory_bus_responder #(.ADDRESS_WIDTH(8), .DATA_WIDTH(16), .ACCESS_LATENCY(0)) dut0 (
    .clock(clock), .reset(reset), .bus(bus0));
  always #5 clock = ~clock;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic access(input logic r, input logic w, input logic [7:0] addr, input logic [15:0] wdat,
                        input logic [1:0] cmd, output int edges, output logic [15:0] rdat);
    bus.address = addr;
    bus.dataOut = wdat;
    bus.commandIn = cmd;
    bus.readEnabled = r;
    bus.writeEnabled = w;
    edges = 0;
    do begin
      @(negedge clock);
      edges++;
    end while (!bus.functionComplete && edges < 40);
    check("complete_seen", bus.functionComplete, 1);
    rdat = bus.dataIn;
    bus.readEnabled = 1'b0;
    bus.writeEnabled = 1'b0;
    @(negedge clock);
    check("complete_fall", bus.functionComplete, 0);
    bus.commandIn = NONE;
    edges = edges - 1;
  endtask
  initial begin
    bus.address = '0; bus.dataOut = '0; bus.readEnabled = 0; bus.writeEnabled = 0;
    bus.commandIn = NONE; bus.snoopyHitIn = 0; bus.snoopyDataIn = '0; bus.snoopyFunctionCompleteIn = 0;
    bus0.address = '0; bus0.dataOut = '0; bus0.readEnabled = 0; bus0.writeEnabled = 0;
    bus0.commandIn = NONE; bus0.snoopyHitIn = 0; bus0.snoopyDataIn = '0; bus0.snoopyFunctionCompleteIn = 0;
    repeat (2) @(negedge clock);
    check("rst_dataIn", bus.dataIn, 0);
    check("rst_complete", bus.functionComplete, 0);
    check("rst_perr", bus.protocolError, 0);
    reset = 1'b1;
    @(negedge clock);
    access(0, 1, 8'h12, 16'hBEEF, BUS_WRITEBACK, n, rd);
    access(0, 1, 8'h05, 16'h0001, BUS_WRITEBACK, n, rd);
    access(0, 1, 8'h20, 16'h5555, BUS_WRITEBACK, n, rd);
    access(1, 0, 8'h12, 16'h0000, BUS_READ, n, rd);
    check("rd12_latency", n, 3);
    check("rd12_data", rd, 16'hBEEF);
    check("rd12_hold", bus.dataIn, 16'hBEEF);
    access(0, 1, 8'h40, 16'h1234, BUS_WRITEBACK, n, rd);
    check("wr40_latency", n, 3);
    access(1, 0, 8'h40, 16'h0000, BUS_READ, n, rd);
    check("rd40_data", rd, 16'h1234);
    bus.address = 8'h05; bus.commandIn = BUS_READ; bus.snoopyHitIn = 1; bus.readEnabled = 1;
    repeat (4) @(negedge clock);
    check("int_waiting", bus.functionComplete, 0);
    bus.snoopyDataIn = 16'hCAFE; bus.snoopyFunctionCompleteIn = 1;
    @(negedge clock);
    check("int_complete", bus.functionComplete, 1);
    check("int_data", bus.dataIn, 16'hCAFE);
    bus.snoopyFunctionCompleteIn = 0; bus.snoopyHitIn = 0; bus.readEnabled = 0;
    @(negedge clock);
    check("int_fall", bus.functionComplete, 0);
    bus.commandIn = NONE;
    access(1, 0, 8'h05, 16'h0000, BUS_READ, n, rd);
`ifdef MEMORY_INTERVENTION_UPDATE_EN
    check("rd05_after_int", rd, 16'hCAFE);
`else
    check("rd05_after_int", rd, 16'h0001);
`endif
    bus.address = 8'h20; bus.commandIn = BUS_READ; bus.snoopyHitIn = 1; bus.snoopyDataIn = 16'hDEAD;
    bus.readEnabled = 1;
    repeat (2) @(negedge clock);
    bus.snoopyHitIn = 0;
    n = 0;
    do begin
      @(negedge clock);
      n++;
    end while (!bus.functionComplete && n < 40);
    check("fallback_edges", n, 4);
    check("fallback_data", bus.dataIn, 16'h5555);
    bus.readEnabled = 0;
    @(negedge clock);
    check("fallback_fall", bus.functionComplete, 0);
    bus.commandIn = NONE;
    access(1, 1, 8'h07, 16'hAAAA, BUS_WRITEBACK, n, rd);
    check("both_latency", n, 3);
    check("both_perr", bus.protocolError, 1);
    access(1, 0, 8'h07, 16'h0000, BUS_READ, n, rd);
    check("rd07_data", rd, 16'hAAAA);
    check("perr_sticky", bus.protocolError, 1);
    access(0, 1, 8'h09, 16'h1111, BUS_WRITEBACK, n, rd);
    bus.address = 8'h09; bus.dataOut = 16'h9999; bus.commandIn = BUS_WRITEBACK; bus.writeEnabled = 1;
    repeat (2) @(negedge clock);
    reset = 1'b0;
    #1;
    check("abort_dataIn", bus.dataIn, 0);
    check("abort_complete", bus.functionComplete, 0);
    check("abort_perr", bus.protocolError, 0);
    @(negedge clock);
    bus.writeEnabled = 0; bus.commandIn = NONE;
    reset = 1'b1;
    @(negedge clock);
    access(1, 0, 8'h09, 16'h0000, BUS_READ, n, rd);
    check("rd09_unchanged", rd, 16'h1111);
    bus0.address = 8'h33; bus0.dataOut = 16'h7777; bus0.commandIn = BUS_WRITEBACK; bus0.writeEnabled = 1;
    n = 0;
    do begin
      @(negedge clock);
      n++;
    end while (!bus0.functionComplete && n < 40);
    check("l0_write_latency", n - 1, 1);
    bus0.writeEnabled = 0;
    @(negedge clock);
    bus0.commandIn = BUS_READ; bus0.readEnabled = 1;
    n = 0;
    do begin
      @(negedge clock);
      n++;
    end while (!bus0.functionComplete && n < 40);
    check("l0_read_latency", n - 1, 1);
    check("l0_read_data", bus0.dataIn, 16'h7777);
    bus0.readEnabled = 0;
    @(negedge clock);
    check("l0_fall", bus0.functionComplete, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end
endmodule
